// File: rtl/snitch_icache_refill_writer_if.sv
// Bus bundle between the icache refill writer, the miss handler, the memory
// side and the lookup stage's write port. The refill writer is the master.
interface snitch_icache_refill_writer_if #(
  parameter int unsigned FETCH_AW   = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned FILL_DW    = 64,
  parameter int unsigned SET_COUNT  = 2,
  parameter int unsigned LINE_COUNT = 128,
  parameter int unsigned ID_WIDTH   = 4
);
  localparam int unsigned LINE_ALIGN  = $clog2(LINE_WIDTH / 8);
  localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT);
  localparam int unsigned SET_ALIGN   = $clog2(SET_COUNT);
  localparam int unsigned TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN;

  // Miss request from the miss handler
  logic [FETCH_AW-1:0]    miss_addr_i;
  logic [ID_WIDTH-1:0]    miss_id_i;
  logic                   miss_valid_i;
  logic                   miss_ready_o;

  // Line fetch towards memory
  logic [FETCH_AW-1:0]    mem_req_addr_o;
  logic                   mem_req_valid_o;
  logic                   mem_req_ready_i;

  // Response beats from memory
  logic [FILL_DW-1:0]     mem_rsp_data_i;
  logic                   mem_rsp_error_i;
  logic                   mem_rsp_last_i;
  logic                   mem_rsp_valid_i;
  logic                   mem_rsp_ready_o;

  // Line write into the lookup stage
  logic [COUNT_ALIGN-1:0] write_addr_o;
  logic [SET_ALIGN-1:0]   write_set_o;
  logic [LINE_WIDTH-1:0]  write_data_o;
  logic [TAG_WIDTH-1:0]   write_tag_o;
  logic                   write_error_o;
  logic                   write_valid_o;
  logic                   write_ready_i;

  // Completion and status
  logic                   done_o;
  logic [ID_WIDTH-1:0]    done_id_o;
  logic                   busy_o;

  modport master (
    input  miss_addr_i, miss_id_i, miss_valid_i,
           mem_req_ready_i,
           mem_rsp_data_i, mem_rsp_error_i, mem_rsp_last_i, mem_rsp_valid_i,
           write_ready_i,
    output miss_ready_o,
           mem_req_addr_o, mem_req_valid_o,
           mem_rsp_ready_o,
           write_addr_o, write_set_o, write_data_o, write_tag_o,
           write_error_o, write_valid_o,
           done_o, done_id_o, busy_o
  );

  modport slave (
    output miss_addr_i, miss_id_i, miss_valid_i,
           mem_req_ready_i,
           mem_rsp_data_i, mem_rsp_error_i, mem_rsp_last_i, mem_rsp_valid_i,
           write_ready_i,
    input  miss_ready_o,
           mem_req_addr_o, mem_req_valid_o,
           mem_rsp_ready_o,
           write_addr_o, write_set_o, write_data_o, write_tag_o,
           write_error_o, write_valid_o,
           done_o, done_id_o, busy_o
  );
endinterface

// File: rtl/snitch_icache_refill_writer.sv
// Icache refill writer: takes one miss at a time, fetches the aligned line
// from memory beat by beat, and writes the assembled line into a round-robin
// victim set of the lookup stage.
module snitch_icache_refill_writer #(
  parameter int unsigned FETCH_AW   = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned FILL_DW    = 64,
  parameter int unsigned SET_COUNT  = 2,
  parameter int unsigned LINE_COUNT = 128,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  snitch_icache_refill_writer_if.master bus
);
  localparam int unsigned LINE_ALIGN  = $clog2(LINE_WIDTH / 8);
  localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT);
  localparam int unsigned SET_ALIGN   = $clog2(SET_COUNT);
  localparam int unsigned TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN;
  localparam int unsigned BEATS       = LINE_WIDTH / FILL_DW;
  localparam int unsigned BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, RECV, WRITE} state_e;

  state_e                state_q, state_d;
  logic [FETCH_AW-1:0]   addr_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [LINE_WIDTH-1:0] data_q;
  logic [BEAT_W-1:0]     beat_q;
  logic                  err_q;
  logic [SET_ALIGN-1:0]  victim_q;

  logic beat_fire;
  logic beat_final;
  logic write_fire;

  assign beat_fire  = (state_q == RECV) && bus.mem_rsp_valid_i;
  assign beat_final = (beat_q == LAST_BEAT) || bus.mem_rsp_last_i;
  assign write_fire = (state_q == WRITE) && bus.write_ready_i;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; valids depend on state only
  always_comb begin
    state_d             = state_q;
    bus.miss_ready_o    = 1'b0;
    bus.mem_req_valid_o = 1'b0;
    bus.mem_rsp_ready_o = 1'b0;
    bus.write_valid_o   = 1'b0;
    bus.done_o          = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.miss_ready_o = 1'b1;
        if (bus.miss_valid_i) state_d = REQ;
      end
      REQ: begin
        bus.mem_req_valid_o = 1'b1;
        if (bus.mem_req_ready_i) state_d = RECV;
      end
      RECV: begin
        bus.mem_rsp_ready_o = 1'b1;
        if (bus.mem_rsp_valid_i && beat_final) state_d = WRITE;
      end
      WRITE: begin
        bus.write_valid_o = 1'b1;
        bus.done_o        = bus.write_ready_i;
        if (bus.write_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Miss capture, line assembly, error tracking and victim rotation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      id_q     <= '0;
      data_q   <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
      victim_q <= '0;
    end else begin
      if ((state_q == IDLE) && bus.miss_valid_i) begin
        addr_q <= bus.miss_addr_i;
        id_q   <= bus.miss_id_i;
        data_q <= '0;
        beat_q <= '0;
        err_q  <= 1'b0;
      end
      if (beat_fire) begin
        for (int unsigned k = 0; k < BEATS; k++) begin
          if (beat_q == BEAT_W'(k)) data_q[k*FILL_DW +: FILL_DW] <= bus.mem_rsp_data_i;
        end
        // A short line (early last) or an overlong one (no last on the final
        // slot) is flagged just like a memory-reported error.
        err_q  <= err_q | bus.mem_rsp_error_i
                | (bus.mem_rsp_last_i && (beat_q != LAST_BEAT))
                | (!bus.mem_rsp_last_i && (beat_q == LAST_BEAT));
        beat_q <= beat_q + 1'b1;
      end
      if (write_fire) begin
        victim_q <= victim_q + 1'b1;
      end
    end
  end

  assign bus.mem_req_addr_o = {addr_q[FETCH_AW-1:LINE_ALIGN], {LINE_ALIGN{1'b0}}};
  assign bus.write_addr_o   = addr_q[LINE_ALIGN +: COUNT_ALIGN];
  assign bus.write_tag_o    = addr_q[FETCH_AW-1 -: TAG_WIDTH];
  assign bus.write_set_o    = victim_q;
  assign bus.write_data_o   = data_q;
  assign bus.write_error_o  = err_q;
  assign bus.done_id_o      = id_q;
  assign bus.busy_o         = (state_q != IDLE);
endmodule

// File: tb/tb_snitch_icache_refill_writer.sv
// Self-checking bench for the icache refill writer: directed scenarios plus
// randomized refills compared against a transaction-level reference model.
module tb_snitch_icache_refill_writer;
  localparam int unsigned FETCH_AW   = 32;
  localparam int unsigned LINE_WIDTH = 128;
  localparam int unsigned FILL_DW    = 64;
  localparam int unsigned SET_COUNT  = 2;
  localparam int unsigned LINE_COUNT = 128;
  localparam int unsigned ID_WIDTH   = 4;

  logic clk_i;
  logic rst_ni;
  int   checks;
  int   errors;
  int   refill_count;

  snitch_icache_refill_writer_if #(
    .FETCH_AW(FETCH_AW), .LINE_WIDTH(LINE_WIDTH), .FILL_DW(FILL_DW),
    .SET_COUNT(SET_COUNT), .LINE_COUNT(LINE_COUNT), .ID_WIDTH(ID_WIDTH)
  ) bus ();

  snitch_icache_refill_writer #(
    .FETCH_AW(FETCH_AW), .LINE_WIDTH(LINE_WIDTH), .FILL_DW(FILL_DW),
    .SET_COUNT(SET_COUNT), .LINE_COUNT(LINE_COUNT), .ID_WIDTH(ID_WIDTH)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // Free-running clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock: inputs change and outputs are sampled at the falling edge
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic clearInputs();
    bus.miss_addr_i     = '0;
    bus.miss_id_i       = '0;
    bus.miss_valid_i    = 1'b0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_data_i  = '0;
    bus.mem_rsp_error_i = 1'b0;
    bus.mem_rsp_last_i  = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    bus.write_ready_i   = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_miss_ready"}, bus.miss_ready_o, 1'b1);
    checkOutput({tag, "_req_valid"}, bus.mem_req_valid_o, 1'b0);
    checkOutput({tag, "_rsp_ready"}, bus.mem_rsp_ready_o, 1'b0);
    checkOutput({tag, "_write_valid"}, bus.write_valid_o, 1'b0);
    checkOutput({tag, "_done"}, bus.done_o, 1'b0);
    checkOutput({tag, "_busy"}, bus.busy_o, 1'b0);
    checkOutput({tag, "_write_data"}, bus.write_data_o, '0);
    checkOutput({tag, "_write_set"}, bus.write_set_o, '0);
    checkOutput({tag, "_write_error"}, bus.write_error_o, 1'b0);
  endtask

  // One complete refill. The expected line, tag, index, error and victim set
  // come from the transaction description, not from the design's structure.
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] id,
                               input int n_sent, input logic last_final,
                               input logic [1:0] err_mask,
                               input logic [63:0] b0, input logic [63:0] b1,
                               input int req_stall, input int rsp_stall,
                               input int wr_stall);
    logic [31:0]  exp_req;
    logic [127:0] exp_line;
    logic [31:0]  exp_idx;
    logic [31:0]  exp_tag;
    logic         exp_err;
    logic [31:0]  exp_set;
    logic [63:0]  beat;
    exp_req  = addr - (addr % 32'd16);
    exp_idx  = (addr / 32'd16) % 32'd128;
    exp_tag  = addr / 32'd2048;
    exp_line = (n_sent >= 2) ? {b1, b0} : {64'h0, b0};
    exp_err  = err_mask[0] || (n_sent >= 2 && err_mask[1]) || (n_sent < 2)
               || (n_sent == 2 && !last_final);
    exp_set  = refill_count % SET_COUNT;

    checkOutput("idle_miss_ready", bus.miss_ready_o, 1'b1);
    checkOutput("idle_busy", bus.busy_o, 1'b0);
    bus.miss_valid_i = 1'b1;
    bus.miss_addr_i  = addr;
    bus.miss_id_i    = id;
    step();
    bus.miss_valid_i = 1'b0;
    bus.miss_addr_i  = $urandom;
    bus.miss_id_i    = 4'($urandom);
    checkOutput("req_valid", bus.mem_req_valid_o, 1'b1);
    checkOutput("req_addr", bus.mem_req_addr_o, exp_req);
    checkOutput("req_busy", bus.busy_o, 1'b1);
    checkOutput("req_miss_ready", bus.miss_ready_o, 1'b0);

    for (int s = 0; s < req_stall; s++) begin
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rsp_data_i  = {$urandom, $urandom};
      bus.mem_rsp_error_i = 1'b1;
      bus.mem_rsp_last_i  = 1'b1;
      #1;
      checkOutput("req_rsp_ready", bus.mem_rsp_ready_o, 1'b0);
      step();
      checkOutput("req_hold", bus.mem_req_valid_o, 1'b1);
    end
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_error_i = 1'b0;
    bus.mem_rsp_last_i  = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    step();
    bus.mem_req_ready_i = 1'b0;
    checkOutput("req_dropped", bus.mem_req_valid_o, 1'b0);

    for (int k = 0; k < n_sent; k++) begin
      for (int s = 0; s < rsp_stall; s++) begin
        checkOutput("recv_ready_stall", bus.mem_rsp_ready_o, 1'b1);
        checkOutput("recv_no_write", bus.write_valid_o, 1'b0);
        step();
      end
      beat = (k == 0) ? b0 : b1;
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rsp_data_i  = beat;
      bus.mem_rsp_error_i = err_mask[k];
      bus.mem_rsp_last_i  = (k == n_sent - 1) ? ((n_sent < 2) ? 1'b1 : last_final) : 1'b0;
      checkOutput("recv_ready", bus.mem_rsp_ready_o, 1'b1);
      step();
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rsp_error_i = 1'b0;
      bus.mem_rsp_last_i  = 1'b0;
    end

    checkOutput("write_valid_latency", bus.write_valid_o, 1'b1);
    checkOutput("write_rsp_ready", bus.mem_rsp_ready_o, 1'b0);
    for (int s = 0; s < wr_stall; s++) begin
      bus.write_ready_i   = 1'b0;
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rsp_data_i  = {$urandom, $urandom};
      bus.mem_rsp_error_i = 1'b1;
      #1;
      checkOutput("wstall_valid", bus.write_valid_o, 1'b1);
      checkOutput("wstall_addr", bus.write_addr_o, exp_idx);
      checkOutput("wstall_tag", bus.write_tag_o, exp_tag);
      checkOutput("wstall_set", bus.write_set_o, exp_set);
      checkOutput("wstall_data", bus.write_data_o, exp_line);
      checkOutput("wstall_error", bus.write_error_o, exp_err);
      checkOutput("wstall_done", bus.done_o, 1'b0);
      checkOutput("wstall_rsp_ready", bus.mem_rsp_ready_o, 1'b0);
      step();
    end
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_error_i = 1'b0;
    bus.write_ready_i   = 1'b1;
    #1;
    checkOutput("write_addr", bus.write_addr_o, exp_idx);
    checkOutput("write_tag", bus.write_tag_o, exp_tag);
    checkOutput("write_set", bus.write_set_o, exp_set);
    checkOutput("write_data", bus.write_data_o, exp_line);
    checkOutput("write_error", bus.write_error_o, exp_err);
    checkOutput("done", bus.done_o, 1'b1);
    checkOutput("done_id", bus.done_id_o, id);
    step();
    bus.write_ready_i = 1'b0;
    refill_count++;
    #1;
    checkOutput("after_done", bus.done_o, 1'b0);
    checkOutput("after_write_valid", bus.write_valid_o, 1'b0);
    checkOutput("after_miss_ready", bus.miss_ready_o, 1'b1);
    checkOutput("after_busy", bus.busy_o, 1'b0);
  endtask

  // Start a refill, take beat 0, then reset asynchronously in the middle
  task automatic resetDuringRecv();
    bus.miss_valid_i = 1'b1;
    bus.miss_addr_i  = 32'h1234_5678;
    bus.miss_id_i    = 4'h9;
    step();
    bus.miss_valid_i    = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    step();
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_data_i  = 64'hDEAD_BEEF_CAFE_F00D;
    bus.mem_rsp_error_i = 1'b1;
    step();
    clearInputs();
    checkOutput("mid_rsp_ready", bus.mem_rsp_ready_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    checkResetOutputs("midrst");
    step();
    checkResetOutputs("midrst_hold");
    rst_ni = 1'b1;
    refill_count = 0;
    step();
  endtask

  initial begin
    logic [31:0] addr;
    int          n_sent;
    logic        last_final;
    logic [1:0]  err_mask;
    checks       = 0;
    errors       = 0;
    refill_count = 0;
    rst_ni       = 1'b0;
    clearInputs();
    @(negedge clk_i);
    @(negedge clk_i);
    checkResetOutputs("reset");
    rst_ni = 1'b1;
    step();

    // Basic two-beat refill
    applyStimulus(32'h8000_1234, 4'd3, 2, 1'b1, 2'b00,
                  64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 0, 0, 0);
    // Lookup back-pressure for five cycles
    applyStimulus(32'h0000_0ABC, 4'd7, 2, 1'b1, 2'b00,
                  64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 0, 0, 5);
    // Memory error on beat 1
    applyStimulus(32'h4000_0100, 4'd1, 2, 1'b1, 2'b10,
                  64'hAAAA_5555_AAAA_5555, 64'h5555_AAAA_5555_AAAA, 0, 0, 0);
    // Early last on beat 0
    applyStimulus(32'h2000_0F00, 4'd12, 1, 1'b1, 2'b00,
                  64'h0F0F_0F0F_0F0F_0F0F, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    // Three misses to index 5 with request/response stalls
    applyStimulus(32'h0000_0058, 4'd2, 2, 1'b1, 2'b00,
                  64'h1, 64'h2, 3, 3, 0);
    applyStimulus(32'h4000_0854, 4'd4, 2, 1'b1, 2'b00,
                  64'h3, 64'h4, 3, 3, 0);
    applyStimulus(32'h7FFF_F85C, 4'd6, 2, 1'b1, 2'b00,
                  64'h5, 64'h6, 3, 3, 0);
    // Final beat without last marker
    applyStimulus(32'hC000_0040, 4'd8, 2, 1'b0, 2'b00,
                  64'h7777_0000_7777_0000, 64'h0000_8888_0000_8888, 1, 0, 1);
    // Reset in the middle of a refill, then a clean refill on set 0
    resetDuringRecv();
    applyStimulus(32'h9000_0230, 4'd5, 2, 1'b1, 2'b00,
                  64'hABCD_0000_0000_0001, 64'hABCD_0000_0000_0002, 0, 0, 0);

    // Randomized refills
    for (int i = 0; i < 40; i++) begin
      addr       = $urandom;
      n_sent     = int'($urandom_range(1, 2));
      last_final = ($urandom_range(0, 3) != 0);
      err_mask   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      applyStimulus(addr, 4'($urandom_range(0, 15)), n_sent, last_final, err_mask,
                    {$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
